// File: rtl/hub_pkg.sv
// Shared hub-bus definitions: size encodings, address width and the DMA state enum.
package hub_pkg;

    localparam int HUB_AW = 16;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_LONG = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ARM,
        DONE
    } dma_state_e;

endpackage

// File: rtl/hub_slot_drv.sv
// Slot output gate: a hub slot's outputs are OR-combined at the top level, so
// everything is forced to zero unless this slot is selected and has a request.
module hub_slot_drv
    import hub_pkg::*;
(
    input  logic              bus_sel,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic [HUB_AW-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              bus_r,
    output logic              bus_e,
    output logic              bus_w,
    output logic [1:0]        bus_s,
    output logic [HUB_AW-1:0] bus_a,
    output logic [31:0]       bus_d
);

    logic win;

    assign win = bus_sel & req;

    always_comb begin
        bus_r = win;
        bus_e = 1'b0;
        bus_w = win & we;
        bus_s = win ? size : 2'b00;
        bus_a = win ? addr : '0;
        bus_d = (win && we) ? wdata : '0;
    end

endmodule

// File: rtl/hub_dma.sv
// Hub block-transfer engine occupying one cog slot; moves runs of longs between
// hub RAM and a local buffer. Optional counters enabled by HUB_DMA_STATS_EN.
module hub_dma
    import hub_pkg::*;
#(
    parameter int LEN_W  = 9,
    parameter int LOC_AW = 9
) (
    input  logic              clk_cog,
    input  logic              res,
    input  logic              ena_bus,
    input  logic              bus_sel,
    output logic              bus_r,
    output logic              bus_e,
    output logic              bus_w,
    output logic [1:0]        bus_s,
    output logic [HUB_AW-1:0] bus_a,
    output logic [31:0]       bus_d,
    input  logic [31:0]       bus_q,
    input  logic              bus_ack,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [HUB_AW-1:0] cmd_hub_addr,
    input  logic [LOC_AW-1:0] cmd_loc_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [LOC_AW-1:0] loc_addr,
    output logic              loc_we,
    output logic [31:0]       loc_wdata,
    input  logic [31:0]       loc_rdata,
    output logic              done,
    output logic              busy
`ifdef HUB_DMA_STATS_EN
    ,
    output logic [31:0]       stat_beats,
    output logic [31:0]       stat_wait
`endif
);

    localparam logic [LOC_AW-1:0] LOC_ONE = 1;
    localparam logic [LEN_W-1:0]  LEN_ONE = 1;

    dma_state_e        state_q, state_d;
    logic              dir_q, dir_d;
    logic [HUB_AW-1:0] hub_addr_q, hub_addr_d;
    logic [LOC_AW-1:0] loc_addr_q, loc_addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [31:0]       data_q, data_d;
    logic              fetch_ph_q, fetch_ph_d;
    logic              beat_ack;

    // The hub phase strobe is not needed: the one-hot select already marks our window.
    logic unused_ena;
    assign unused_ena = ena_bus;

    assign beat_ack  = (state_q == ARM) && bus_ack;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign loc_addr  = loc_addr_q;
    assign loc_wdata = bus_q;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        hub_addr_d = hub_addr_q;
        loc_addr_d = loc_addr_q;
        rem_d      = rem_q;
        data_d     = data_q;
        fetch_ph_d = fetch_ph_q;
        loc_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    dir_d      = cmd_dir;
                    hub_addr_d = cmd_hub_addr & 16'hFFFC;
                    loc_addr_d = cmd_loc_addr;
                    rem_d      = cmd_len;
                    data_d     = '0;
                    fetch_ph_d = 1'b0;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else if (cmd_dir) begin
                        state_d = FETCH;
                    end else begin
                        state_d = ARM;
                    end
                end
            end
            // Phase 0 presents the address; the RAM answers one cycle later in phase 1.
            FETCH: begin
                if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    data_d     = loc_rdata;
                    fetch_ph_d = 1'b0;
                    state_d    = ARM;
                end
            end
            ARM: begin
                if (bus_ack) begin
                    loc_we     = ~dir_q;
                    hub_addr_d = hub_addr_q + 16'd4;
                    loc_addr_d = loc_addr_q + LOC_ONE;
                    rem_d      = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_d = DONE;
                    end else if (dir_q) begin
                        state_d = FETCH;
                    end else begin
                        state_d = ARM;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            hub_addr_q <= '0;
            loc_addr_q <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            fetch_ph_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            hub_addr_q <= hub_addr_d;
            loc_addr_q <= loc_addr_d;
            rem_q      <= rem_d;
            data_q     <= data_d;
            fetch_ph_q <= fetch_ph_d;
        end
    end

    hub_slot_drv u_slot_drv (
        .bus_sel (bus_sel),
        .req     (state_q == ARM),
        .we      (dir_q),
        .size    (SZ_LONG),
        .addr    (hub_addr_q),
        .wdata   (data_q),
        .bus_r   (bus_r),
        .bus_e   (bus_e),
        .bus_w   (bus_w),
        .bus_s   (bus_s),
        .bus_a   (bus_a),
        .bus_d   (bus_d)
    );

`ifdef HUB_DMA_STATS_EN
    logic [31:0] beats_q, beats_d;
    logic [31:0] wait_q, wait_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        beats_d = beats_q;
        wait_d  = wait_q;
        if (beat_ack && (beats_q != 32'hFFFF_FFFF)) begin
            beats_d = beats_q + 32'd1;
        end
        if ((state_q == ARM) && (wait_q != 32'hFFFF_FFFF)) begin
            wait_d = wait_q + 32'd1;
        end
    end

    always_ff @(posedge clk_cog or posedge res) begin
        if (res) begin
            beats_q <= '0;
            wait_q  <= '0;
        end else begin
            beats_q <= beats_d;
            wait_q  <= wait_d;
        end
    end

    assign stat_beats = beats_q;
    assign stat_wait  = wait_q;
`else
    logic unused_beat_ack;
    assign unused_beat_ack = beat_ack;
`endif

endmodule

// File: tb/tb_hub_dma.sv
// Self-checking bench for hub_dma: a hub model with a 1-in-16 slot window, a local
// RAM model, and a transaction-level scoreboard of expected beats and local writes.
`timescale 1ns/1ps
module tb_hub_dma;

    localparam int LEN_W  = 9;
    localparam int LOC_AW = 9;
    localparam int SLOT   = 5;

    logic              clk_cog = 1'b0;
    logic              res = 1'b1;
    logic              ena_bus = 1'b0;
    logic              bus_sel = 1'b0;
    logic              bus_r, bus_e, bus_w;
    logic [1:0]        bus_s;
    logic [15:0]       bus_a;
    logic [31:0]       bus_d;
    logic [31:0]       bus_q = '0;
    logic              bus_ack = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_dir = 1'b0;
    logic [15:0]       cmd_hub_addr = '0;
    logic [LOC_AW-1:0] cmd_loc_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [LOC_AW-1:0] loc_addr;
    logic              loc_we;
    logic [31:0]       loc_wdata;
    logic [31:0]       loc_rdata = '0;
    logic              done, busy;

    hub_dma #(.LEN_W(LEN_W), .LOC_AW(LOC_AW)) dut (
        .clk_cog(clk_cog), .res(res), .ena_bus(ena_bus), .bus_sel(bus_sel),
        .bus_r(bus_r), .bus_e(bus_e), .bus_w(bus_w), .bus_s(bus_s),
        .bus_a(bus_a), .bus_d(bus_d), .bus_q(bus_q), .bus_ack(bus_ack),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
        .cmd_hub_addr(cmd_hub_addr), .cmd_loc_addr(cmd_loc_addr), .cmd_len(cmd_len),
        .loc_addr(loc_addr), .loc_we(loc_we), .loc_wdata(loc_wdata),
        .loc_rdata(loc_rdata), .done(done), .busy(busy)
    );

    always #5 clk_cog = ~clk_cog;

    typedef struct {
        logic [15:0] a;
        logic        w;
        logic [31:0] d;
    } beat_t;

    typedef struct {
        logic [LOC_AW-1:0] a;
        logic [31:0]       d;
    } lw_t;

    logic [31:0] hub_mem [0:16383];
    logic [31:0] loc_mem [0:(1<<LOC_AW)-1];

    beat_t       exp_beats[$];
    lw_t         exp_lw[$];
    beat_t       b;
    lw_t         l;
    logic [15:0] ack_addr_log[$];
    logic [31:0] ack_data_log[$];
    logic [15:0] req_addr_log[$];

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int beat_cnt = 0;
    int req_cnt  = 0;
    int withhold = 0;
    bit stray_ack = 1'b0;
    int hub_cyc = 0;
    int t, base, done_base, req_base;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkAck(input int i, input logic [15:0] ea, input logic [31:0] ed, input bit chk_d);
        logic [15:0] aa;
        logic [31:0] ad;
        aa = (i < ack_addr_log.size()) ? ack_addr_log[i] : 16'hxxxx;
        ad = (i < ack_data_log.size()) ? ack_data_log[i] : 32'hxxxx_xxxx;
        checkOutput($sformatf("ack_addr[%0d]", i), aa, ea);
        if (chk_d) checkOutput($sformatf("ack_data[%0d]", i), ad, ed);
    endtask

    // Expected traffic of one command, computed from addresses and memory contents.
    task automatic modelCmd(input bit dir, input logic [15:0] ha, input logic [LOC_AW-1:0] la,
                            input int len);
        beat_t             nb;
        lw_t               nl;
        logic [15:0]       a;
        logic [LOC_AW-1:0] lx;
        for (int i = 0; i < len; i++) begin
            a  = (ha & 16'hFFFC) + 16'(4 * i);
            lx = la + LOC_AW'(i);
            nb.a = a;
            nb.w = dir;
            nb.d = dir ? loc_mem[lx] : 32'h0;
            exp_beats.push_back(nb);
            if (!dir) begin
                nl.a = lx;
                nl.d = hub_mem[a[15:2]];
                exp_lw.push_back(nl);
            end
        end
    endtask

    task automatic applyStimulus(input bit dir, input logic [15:0] ha, input logic [LOC_AW-1:0] la,
                                 input int len);
        int w;
        w = 0;
        @(negedge clk_cog);
        while (cmd_ready !== 1'b1 && w < 200) begin
            @(negedge clk_cog);
            w++;
        end
        checkOutput("cmd_ready_before_cmd", cmd_ready, 1);
        modelCmd(dir, ha, la, len);
        cmd_dir      = dir;
        cmd_hub_addr = ha;
        cmd_loc_addr = la;
        cmd_len      = LEN_W'(len);
        cmd_valid    = 1'b1;
        @(posedge clk_cog);
        #1;
        cmd_valid = 1'b0;
        checkOutput("cmd_ready_drop", cmd_ready, 0);
    endtask

    task automatic waitDone(input string name, input int budget);
        int start;
        int w;
        start = done_cnt;
        w = 0;
        while (done_cnt == start && w < budget) begin
            @(negedge clk_cog);
            #3;
            w++;
        end
        repeat (3) @(negedge clk_cog);
        #3;
        checkOutput({name, "_done_pulses"}, done_cnt - start, 1);
        checkOutput({name, "_beats_left"}, exp_beats.size(), 0);
        checkOutput({name, "_locwr_left"}, exp_lw.size(), 0);
        checkOutput({name, "_ready_after"}, cmd_ready, 1);
    endtask

    task automatic clearLogs();
        ack_addr_log.delete();
        ack_data_log.delete();
        req_addr_log.delete();
    endtask

    // Hub model: opens the slot window once per rotation and answers requests.
    initial begin
        forever begin
            @(negedge clk_cog);
            ena_bus = ~ena_bus;
            bus_sel = ((hub_cyc % 16) == SLOT);
            bus_ack = 1'b0;
            bus_q   = '0;
            hub_cyc++;
            #1;
            if (bus_sel) begin
                if (bus_r) begin
                    req_cnt++;
                    req_addr_log.push_back(bus_a);
                    if (withhold > 0) begin
                        withhold--;
                    end else begin
                        bus_ack = 1'b1;
                        if (!bus_w) bus_q = hub_mem[bus_a[15:2]];
                        else        hub_mem[bus_a[15:2]] = bus_d;
                    end
                end else if (stray_ack) begin
                    bus_ack   = 1'b1;
                    bus_q     = 32'hDEAD_BEEF;
                    stray_ack = 1'b0;
                end
            end
        end
    end

    // Local RAM model with one cycle of read latency.
    initial begin
        logic [LOC_AW-1:0] ra;
        logic              rwe;
        logic [31:0]       rwd;
        forever begin
            @(negedge clk_cog);
            #4;
            ra  = loc_addr;
            rwe = loc_we;
            rwd = loc_wdata;
            @(posedge clk_cog);
            #1;
            loc_rdata = loc_mem[ra];
            if (rwe) loc_mem[ra] = rwd;
        end
    end

    // Scoreboard compare, every cycle.
    initial begin
        forever begin
            @(negedge clk_cog);
            #2;
            if (!bus_sel) begin
                checkOutput("bus_gated", {bus_r, bus_e, bus_w, bus_s, bus_a, bus_d}, 0);
            end
            checkOutput("busy_not_ready", busy, !cmd_ready);
            if (bus_ack && bus_r) begin
                beat_cnt++;
                ack_addr_log.push_back(bus_a);
                ack_data_log.push_back(bus_d);
                if (exp_beats.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("[TB] FAIL unexpected_beat: got addr %h, expected no beat", bus_a);
                end else begin
                    b = exp_beats.pop_front();
                    checkOutput("beat_addr", bus_a, b.a);
                    checkOutput("beat_w", bus_w, b.w);
                    checkOutput("beat_d", bus_d, b.d);
                    checkOutput("beat_s", bus_s, 2'b10);
                    checkOutput("beat_e", bus_e, 0);
                end
            end
            if (loc_we) begin
                if (exp_lw.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("[TB] FAIL unexpected_loc_we: got addr %h, expected no write", loc_addr);
                end else begin
                    l = exp_lw.pop_front();
                    checkOutput("loc_wr_addr", loc_addr, l.a);
                    checkOutput("loc_wr_data", loc_wdata, l.d);
                end
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16384; i++) hub_mem[i] = '0;
        for (int i = 0; i < (1 << LOC_AW); i++) loc_mem[i] = '0;

        // Reset state
        #2;
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_loc_we", loc_we, 0);
        checkOutput("rst_bus", {bus_r, bus_e, bus_w, bus_s, bus_a, bus_d}, 0);
        repeat (3) @(negedge clk_cog);
        res = 1'b0;

        // Read 4 longs from 0x0100 to local 0
        for (int i = 0; i < 4; i++) hub_mem[64 + i] = 32'hA0 + 32'(i);
        clearLogs();
        applyStimulus(1'b0, 16'h0100, 9'd0, 4);
        waitDone("rd4", 400);
        checkOutput("rd4_acks", ack_addr_log.size(), 4);
        checkAck(0, 16'h0100, 0, 1'b1);
        checkAck(1, 16'h0104, 0, 1'b1);
        checkAck(2, 16'h0108, 0, 1'b1);
        checkAck(3, 16'h010C, 0, 1'b1);
        checkOutput("rd4_loc0", loc_mem[0], 32'hA0);
        checkOutput("rd4_loc1", loc_mem[1], 32'hA1);
        checkOutput("rd4_loc2", loc_mem[2], 32'hA2);
        checkOutput("rd4_loc3", loc_mem[3], 32'hA3);

        // Write 3 longs from local 10 to hub 0x2002 (low bits ignored)
        loc_mem[10] = 32'h11;
        loc_mem[11] = 32'h22;
        loc_mem[12] = 32'h33;
        clearLogs();
        applyStimulus(1'b1, 16'h2002, 9'd10, 3);
        waitDone("wr3", 400);
        checkOutput("wr3_acks", ack_addr_log.size(), 3);
        checkAck(0, 16'h2000, 32'h11, 1'b1);
        checkAck(1, 16'h2004, 32'h22, 1'b1);
        checkAck(2, 16'h2008, 32'h33, 1'b1);
        checkOutput("wr3_hub", hub_mem[16'h2004 >> 2], 32'h22);
        checkOutput("wr3_loc10", loc_mem[10], 32'h11);
        checkOutput("wr3_loc11", loc_mem[11], 32'h22);
        checkOutput("wr3_loc12", loc_mem[12], 32'h33);

        // Withheld ack: same address is re-presented at the next window
        hub_mem[16'h0300 >> 2] = 32'h55;
        clearLogs();
        withhold = 1;
        applyStimulus(1'b0, 16'h0300, 9'd5, 1);
        waitDone("hold", 400);
        checkOutput("hold_reqs", req_addr_log.size(), 2);
        checkOutput("hold_req0", (req_addr_log.size() > 0) ? req_addr_log[0] : 16'hxxxx, 16'h0300);
        checkOutput("hold_req1", (req_addr_log.size() > 1) ? req_addr_log[1] : 16'hxxxx, 16'h0300);
        checkOutput("hold_acks", ack_addr_log.size(), 1);
        checkOutput("hold_loc5", loc_mem[5], 32'h55);

        // Hub and local address wrap
        hub_mem[16'hFFFC >> 2] = 32'hF0F0_0001;
        hub_mem[0]             = 32'h0000_0B0B;
        clearLogs();
        applyStimulus(1'b0, 16'hFFFC, 9'd511, 2);
        waitDone("wrap", 400);
        checkOutput("wrap_acks", ack_addr_log.size(), 2);
        checkAck(0, 16'hFFFC, 0, 1'b1);
        checkAck(1, 16'h0000, 0, 1'b1);
        checkOutput("wrap_loc511", loc_mem[511], 32'hF0F0_0001);
        checkOutput("wrap_loc0", loc_mem[0], 32'h0000_0B0B);

        // Zero-length command
        req_base  = req_cnt;
        done_base = done_cnt;
        applyStimulus(1'b0, 16'h4000, 9'd0, 0);
        checkOutput("len0_done_now", done, 1);
        @(posedge clk_cog);
        #1;
        checkOutput("len0_done_gone", done, 0);
        checkOutput("len0_ready", cmd_ready, 1);
        repeat (20) @(negedge clk_cog);
        #3;
        checkOutput("len0_no_req", req_cnt - req_base, 0);
        checkOutput("len0_one_done", done_cnt - done_base, 1);

        // Stray ack while idle
        done_base = done_cnt;
        stray_ack = 1'b1;
        repeat (20) @(negedge clk_cog);
        #3;
        checkOutput("stray_busy", busy, 0);
        checkOutput("stray_no_done", done_cnt - done_base, 0);

        // Reset in the middle of an 8-long read
        for (int i = 0; i < 8; i++) hub_mem[(16'h0800 >> 2) + i] = 32'hC0 + 32'(i);
        clearLogs();
        base = beat_cnt;
        applyStimulus(1'b0, 16'h0800, 9'd40, 8);
        t = 0;
        while (beat_cnt < base + 2 && t < 200) begin
            @(negedge clk_cog);
            #3;
            t++;
        end
        checkOutput("rst_two_acks", beat_cnt - base, 2);
        withhold = 1;
        t = 0;
        do begin
            @(negedge clk_cog);
            #3;
            t++;
        end while (!(bus_sel && bus_r) && t < 40);
        checkOutput("rst_window_req", bus_r, 1);
        done_base = done_cnt;
        res = 1'b1;
        #0.5;
        checkOutput("rst_mid_bus", {bus_r, bus_e, bus_w, bus_s, bus_a, bus_d}, 0);
        checkOutput("rst_mid_loc_we", loc_we, 0);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_done", done, 0);
        exp_beats.delete();
        exp_lw.delete();
        repeat (2) @(negedge clk_cog);
        res = 1'b0;
        stray_ack = 1'b1;
        repeat (20) @(negedge clk_cog);
        #3;
        checkOutput("rst_no_done", done_cnt - done_base, 0);
        checkOutput("rst_ready", cmd_ready, 1);
        checkOutput("rst_loc40", loc_mem[40], 32'hC0);
        checkOutput("rst_loc41", loc_mem[41], 32'hC1);
        checkOutput("rst_loc42", loc_mem[42], 32'h0);

        // Fresh command after reset
        hub_mem[16'h0900 >> 2]       = 32'hE0;
        hub_mem[(16'h0900 >> 2) + 1] = 32'hE1;
        clearLogs();
        applyStimulus(1'b0, 16'h0900, 9'd60, 2);
        waitDone("fresh", 400);
        checkAck(0, 16'h0900, 0, 1'b1);
        checkAck(1, 16'h0904, 0, 1'b1);
        checkOutput("fresh_loc60", loc_mem[60], 32'hE0);
        checkOutput("fresh_loc61", loc_mem[61], 32'hE1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
